// File: rtl/mem_bus_bridge.sv
// Bridges the pipeline MEM stage to a simple req/ack word bus.
// Stalls the pipeline for each access, with a misalignment trap and a bus-timeout abort.
module mem_bus_bridge #(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic        mem_en,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        mem_err,
    output logic        err_sticky,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic              bus_we_nxt;
    logic [31:0]       bus_addr_nxt, bus_wdata_nxt, mem_din_nxt;
    logic              mem_err_nxt, err_sticky_nxt;
    logic              access, aligned, timeout_hit;

    assign access      = mem_valid & (mem_ren | mem_wen);
    assign aligned     = (mem_addr[1:0] == 2'b00);
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

    assign mem_stall = ((state == IDLE) && access) || (state == REQ);
    assign bus_req   = (state == REQ);

    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = wait_cnt;
        bus_we_nxt     = bus_we;
        bus_addr_nxt   = bus_addr;
        bus_wdata_nxt  = bus_wdata;
        mem_din_nxt    = mem_din;
        mem_err_nxt    = 1'b0;
        err_sticky_nxt = err_sticky;
        case (state)
            IDLE: begin
                if (access) begin
                    if (aligned) begin
                        state_nxt     = REQ;
                        wait_cnt_nxt  = '0;
                        bus_addr_nxt  = {mem_addr[31:2], 2'b00};
                        bus_wdata_nxt = mem_dout;
                        // ren and wen together is a store
                        bus_we_nxt    = mem_wen;
                    end else begin
                        state_nxt      = DONE;
                        mem_err_nxt    = 1'b1;
                        err_sticky_nxt = 1'b1;
                        if (!mem_wen) mem_din_nxt = ERR_DATA;
                    end
                end
            end
            REQ: begin
                // The registered bus_we decides read/write; mem_* inputs are ignored here
                if (bus_ack) begin
                    state_nxt = DONE;
                    if (!bus_we) mem_din_nxt = bus_rdata;
                end else if (timeout_hit) begin
                    state_nxt      = DONE;
                    mem_err_nxt    = 1'b1;
                    err_sticky_nxt = 1'b1;
                    if (!bus_we) mem_din_nxt = ERR_DATA;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            DONE: begin
                if (mem_en) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            mem_din    <= '0;
            mem_err    <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            bus_we     <= bus_we_nxt;
            bus_addr   <= bus_addr_nxt;
            bus_wdata  <= bus_wdata_nxt;
            mem_din    <= mem_din_nxt;
            mem_err    <= mem_err_nxt;
            err_sticky <= err_sticky_nxt;
        end
    end

endmodule
